// File: rtl/fetch_ctrl_if.sv
// Instruction-side SRAM-like bus: request/address out, address/data handshakes in.
interface fetch_ctrl_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_addr_ok_i,
        input  inst_data_ok_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_addr_ok_i,
        output inst_data_ok_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding instruction-bus request, a one-entry skid
// buffer for decode stalls, and cancellation of in-flight fetches on redirect.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_f_i,
    input  logic         flush_i,
    input  logic         stall_d_i,
    fetch_ctrl_if.master bus,
    output logic [31:0]  inst_o,
    output logic [31:0]  inst_pc_o,
    output logic         inst_valid_o,
    output logic         adel_o,
    output logic         stall_f_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc_pend;
    logic [31:0] skid_data;
    logic [31:0] skid_pc;

    logic        out_free;
    logic        req;
    logic        pend_ld;
    logic        skid_ld;
    logic        deliver;
    logic        load;
    logic [31:0] load_data;
    logic [31:0] load_pc;
    logic        load_adel;

    assign out_free = ~inst_valid_o | ~stall_d_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_REQ;
        else     state <= next_state;
    end

    // Next state, bus request and output-register load selection.
    // deliver marks bus/adel deliveries that release the PC; the skid move
    // loads the output register without releasing it a second time.
    always_comb begin
        next_state = state;
        req        = 1'b0;
        pend_ld    = 1'b0;
        skid_ld    = 1'b0;
        deliver    = 1'b0;
        load       = 1'b0;
        load_data  = '0;
        load_pc    = pc_f_i;
        load_adel  = 1'b0;
        unique case (state)
            S_REQ: begin
                if (pc_f_i[1:0] == 2'b00) begin
                    req = 1'b1;
                    if (bus.inst_addr_ok_i) begin
                        pend_ld    = 1'b1;
                        next_state = flush_i ? S_DROP : S_WAIT;
                    end
                end else if (out_free && !flush_i) begin
                    deliver   = 1'b1;
                    load      = 1'b1;
                    load_data = '0;
                    load_pc   = pc_f_i;
                    load_adel = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    next_state = bus.inst_data_ok_i ? S_REQ : S_DROP;
                end else if (bus.inst_data_ok_i) begin
                    if (out_free) begin
                        deliver    = 1'b1;
                        load       = 1'b1;
                        load_data  = bus.inst_rdata_i;
                        load_pc    = pc_pend;
                        next_state = S_REQ;
                    end else begin
                        skid_ld    = 1'b1;
                        next_state = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    next_state = S_REQ;
                end else if (!stall_d_i) begin
                    load       = 1'b1;
                    load_data  = skid_data;
                    load_pc    = skid_pc;
                    next_state = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.inst_data_ok_i) next_state = S_REQ;
            end
            default: next_state = S_REQ;
        endcase
    end

    assign bus.inst_req_o  = req & ~rst;
    assign bus.inst_addr_o = pc_f_i;
    assign stall_f_o       = ~(flush_i | deliver | skid_ld);

    // Pending-PC, skid buffer and decode-facing output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_pend      <= '0;
            skid_data    <= '0;
            skid_pc      <= '0;
            inst_o       <= '0;
            inst_pc_o    <= RESET_PC;
            adel_o       <= 1'b0;
            inst_valid_o <= 1'b0;
        end else begin
            if (pend_ld) pc_pend <= pc_f_i;
            if (skid_ld) begin
                skid_data <= bus.inst_rdata_i;
                skid_pc   <= pc_pend;
            end else if (state == S_HOLD && flush_i) begin
                skid_data <= '0;
                skid_pc   <= '0;
            end
            if (flush_i) begin
                inst_valid_o <= 1'b0;
            end else if (load) begin
                inst_o       <= load_data;
                inst_pc_o    <= load_pc;
                adel_o       <= load_adel;
                inst_valid_o <= 1'b1;
            end else if (!stall_d_i) begin
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule
